// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Booth window encodings, FSM states and step-count derivations.
package multdiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        DIV_FIX,
        DONE
    } state_e;

    // Datapath control bundle: add/sub select, accumulator hold, 2x multiplicand select.
    typedef struct packed {
        logic operation;
        logic nop;
        logic shift;
    } dp_ctrl_t;

    localparam dp_ctrl_t CTRL_HOLD = '{operation: 1'b0, nop: 1'b1, shift: 1'b0};

    // Booth radix-4 windows {b[i+1], b[i], b[i-1]} named by the multiple they select.
    localparam logic [2:0] BOOTH_ZERO_P = 3'b000;
    localparam logic [2:0] BOOTH_P1_A   = 3'b001;
    localparam logic [2:0] BOOTH_P1_B   = 3'b010;
    localparam logic [2:0] BOOTH_P2     = 3'b011;
    localparam logic [2:0] BOOTH_M2     = 3'b100;
    localparam logic [2:0] BOOTH_M1_A   = 3'b101;
    localparam logic [2:0] BOOTH_M1_B   = 3'b110;
    localparam logic [2:0] BOOTH_ZERO_M = 3'b111;

    function automatic int unsigned mult_steps(input int unsigned width);
        return width / 2;
    endfunction

    function automatic int unsigned div_steps(input int unsigned width);
        return width;
    endfunction

endpackage

// File: rtl/multdiv_booth_decode.sv
// Radix-4 Booth window decoder: 3-bit multiplier window to datapath controls.
module multdiv_booth_decode
    import multdiv_pkg::*;
(
    input  logic [2:0] window,
    output dp_ctrl_t   ctrl
);

    always_comb begin
        ctrl = '{operation: 1'b0, nop: 1'b0, shift: 1'b0};
        unique case (window)
            BOOTH_ZERO_P, BOOTH_ZERO_M: ctrl.nop = 1'b1;
            BOOTH_P1_A, BOOTH_P1_B:     ctrl.operation = 1'b0;
            BOOTH_P2:                   ctrl.shift = 1'b1;
            BOOTH_M2: begin
                ctrl.operation = 1'b1;
                ctrl.shift     = 1'b1;
            end
            BOOTH_M1_A, BOOTH_M1_B:     ctrl.operation = 1'b1;
        endcase
    end

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequencing FSM for the shared Booth multiplier / non-restoring divider datapath.
// All outputs are registered; they are computed from the next state and current inputs.
module multdiv_seq_ctrl
    import multdiv_pkg::*;
#(
    parameter  int unsigned WIDTH      = 32,
    localparam int unsigned MULT_STEPS = mult_steps(WIDTH),
    localparam int unsigned DIV_STEPS  = div_steps(WIDTH),
    localparam int unsigned CNT_W      = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             divisor_zero,
    input  logic [2:0]       booth_window,
    input  logic             div_msb,
    input  logic             div_sign,
    output logic             operation,
    output logic             nop,
    output logic             shift,
    output logic             busy,
    output logic             ready,
    output logic             op_mult,
    output logic             op_div,
    output logic             div_ready,
    output logic             div_by_zero,
    output logic [CNT_W-1:0] step
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;
    dp_ctrl_t         ctrl_q, ctrl_d;
    dp_ctrl_t         booth_ctrl;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             op_mult_q, op_mult_d;
    logic             op_div_q, op_div_d;
    logic             div_ready_q, div_ready_d;
    logic             dbz_q, dbz_d;

    multdiv_booth_decode u_booth_decode (
        .window (booth_window),
        .ctrl   (booth_ctrl)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        op_mult_d   = op_mult_q;
        op_div_d    = op_div_q;
        div_ready_d = div_ready_q;
        dbz_d       = dbz_q;
        ctrl_d      = CTRL_HOLD;

        // A new start aborts whatever is in flight; multiply wins a tie.
        if (start_mult || start_div) begin
            step_d      = '0;
            div_ready_d = 1'b0;
            dbz_d       = 1'b0;
            op_mult_d   = start_mult;
            op_div_d    = !start_mult;
            if (start_mult) begin
                state_d = MULT;
            end else if (divisor_zero) begin
                state_d = DONE;
                dbz_d   = 1'b1;
            end else begin
                state_d = DIV;
            end
        end else begin
            case (state_q)
                MULT: begin
                    if (step_q == CNT_W'(MULT_STEPS - 1)) state_d = DONE;
                    else step_d = step_q + CNT_W'(1);
                end
                DIV: begin
                    if (step_q == CNT_W'(DIV_STEPS - 1)) state_d = DIV_FIX;
                    else step_d = step_q + CNT_W'(1);
                end
                DIV_FIX: state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (state_d == DONE) div_ready_d = op_div_d;

        case (state_d)
            MULT: ctrl_d = booth_ctrl;
            DIV: begin
                ctrl_d.operation = div_sign ? div_msb : !div_msb;
                ctrl_d.nop       = 1'b0;
            end
            DIV_FIX: begin
                // Restore the remainder only when its sign disagrees with the divisor.
                if (div_msb != div_sign) begin
                    ctrl_d.operation = div_sign;
                    ctrl_d.nop       = 1'b0;
                end
            end
            default: ctrl_d = CTRL_HOLD;
        endcase

        busy_d  = state_d inside {MULT, DIV, DIV_FIX};
        ready_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            ctrl_q      <= '{operation: 1'b0, nop: 1'b0, shift: 1'b0};
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            op_mult_q   <= 1'b0;
            op_div_q    <= 1'b0;
            div_ready_q <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            ctrl_q      <= ctrl_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            op_mult_q   <= op_mult_d;
            op_div_q    <= op_div_d;
            div_ready_q <= div_ready_d;
            dbz_q       <= dbz_d;
        end
    end

    assign operation   = ctrl_q.operation;
    assign nop         = ctrl_q.nop;
    assign shift       = ctrl_q.shift;
    assign busy        = busy_q;
    assign ready       = ready_q;
    assign op_mult     = op_mult_q;
    assign op_div      = op_div_q;
    assign div_ready   = div_ready_q;
    assign div_by_zero = dbz_q;
    assign step        = step_q;

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Scoreboard bench for multdiv_seq_ctrl at WIDTH=32: directed starts push expected
// per-cycle output snapshots and completions; a negedge monitor pops and compares.
module tb_multdiv_seq_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_mult, start_div, divisor_zero;
    logic [2:0] booth_window;
    logic       div_msb, div_sign;
    logic       operation, nop, shift, busy, ready;
    logic       op_mult, op_div, div_ready, div_by_zero;
    logic [5:0] step;

    typedef struct packed {
        logic       operation;
        logic       nop;
        logic       shift;
        logic       busy;
        logic       ready;
        logic       op_mult;
        logic       op_div;
        logic       div_ready;
        logic       dbz;
        logic [5:0] step;
    } out_t;

    typedef struct {
        int   cyc;
        out_t exp;
    } snap_t;

    typedef struct {
        int         cyc;
        logic [3:0] flags;
    } done_t;

    snap_t snap_q[$];
    done_t done_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    passes = 0;

    multdiv_seq_ctrl #(.WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .start_mult   (start_mult),
        .start_div    (start_div),
        .divisor_zero (divisor_zero),
        .booth_window (booth_window),
        .div_msb      (div_msb),
        .div_sign     (div_sign),
        .operation    (operation),
        .nop          (nop),
        .shift        (shift),
        .busy         (busy),
        .ready        (ready),
        .op_mult      (op_mult),
        .op_div       (op_div),
        .div_ready    (div_ready),
        .div_by_zero  (div_by_zero),
        .step         (step)
    );

    always #5 clock = !clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic out_t mk(logic op, logic np, logic sh, logic bz, logic rd,
                                logic om, logic od, logic dr, logic dz, int st);
        out_t o;
        o = '{operation: op, nop: np, shift: sh, busy: bz, ready: rd,
              op_mult: om, op_div: od, div_ready: dr, dbz: dz, step: 6'(st)};
        return o;
    endfunction

    function automatic void expect_at(int c, out_t e);
        snap_t s;
        s.cyc = c;
        s.exp = e;
        snap_q.push_back(s);
    endfunction

    function automatic void expect_done(int c, logic om, logic od, logic dr, logic dz);
        done_t d;
        d.cyc   = c;
        d.flags = {om, od, dr, dz};
        done_q.push_back(d);
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: per-cycle snapshot checks and completion scoreboard.
    out_t  act;
    snap_t s_pop;
    done_t d_pop;
    always @(negedge clock) begin
        act = '{operation: operation, nop: nop, shift: shift, busy: busy, ready: ready,
                op_mult: op_mult, op_div: op_div, div_ready: div_ready, dbz: div_by_zero,
                step: step};
        while (snap_q.size() > 0 && snap_q[0].cyc < cyc) begin
            s_pop = snap_q.pop_front();
            checks++;
            $display("FAIL snap_missed: cycle %0d passed unchecked (now %0d)", s_pop.cyc, cyc);
        end
        if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
            s_pop = snap_q.pop_front();
            checks++;
            if (act == s_pop.exp) passes++;
            else $display("FAIL snap@%0d: got %h expected %h", cyc, act, s_pop.exp);
        end
        if (ready) begin
            checks++;
            if (done_q.size() == 0) begin
                $display("FAIL unexpected_ready@%0d: got ready=1 expected 0", cyc);
            end else begin
                d_pop = done_q.pop_front();
                if (d_pop.cyc == cyc &&
                    d_pop.flags == {op_mult, op_div, div_ready, div_by_zero}) passes++;
                else $display("FAIL done: got cycle %0d flags %b expected cycle %0d flags %b",
                              cyc, {op_mult, op_div, div_ready, div_by_zero},
                              d_pop.cyc, d_pop.flags);
            end
        end
    end

    logic [2:0] sweep_tbl [8];
    int c0, c1;

    initial begin
        sweep_tbl[0] = 3'b010; sweep_tbl[1] = 3'b000; sweep_tbl[2] = 3'b000; sweep_tbl[3] = 3'b001;
        sweep_tbl[4] = 3'b101; sweep_tbl[5] = 3'b100; sweep_tbl[6] = 3'b100; sweep_tbl[7] = 3'b010;

        reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; divisor_zero = 1'b0;
        booth_window = 3'b000; div_msb = 1'b0; div_sign = 1'b0;
        tick(3);
        expect_at(cyc, mk(0,0,0,0,0, 0,0,0,0, 0));
        expect_at(cyc + 1, mk(0,1,0,0,0, 0,0,0,0, 0));
        reset = 1'b0;
        tick(3);

        // Multiply with window 100 held: subtract 2x every step.
        c0 = cyc;
        for (int k = 1; k <= 16; k++) expect_at(c0 + k, mk(1,0,1,1,0, 1,0,0,0, k - 1));
        expect_at(c0 + 17, mk(0,1,0,0,1, 1,0,0,0, 15));
        expect_at(c0 + 18, mk(0,1,0,0,0, 1,0,0,0, 15));
        expect_done(c0 + 17, 1, 0, 0, 0);
        booth_window = 3'b100; start_mult = 1'b1;
        tick(1);
        start_mult = 1'b0;
        tick(20);

        // Divide, positive divisor, negative remainder: add each step then restore.
        c0 = cyc;
        for (int k = 1; k <= 32; k++) expect_at(c0 + k, mk(0,0,0,1,0, 0,1,0,0, k - 1));
        expect_at(c0 + 33, mk(0,0,0,1,0, 0,1,0,0, 31));
        expect_at(c0 + 34, mk(0,1,0,0,1, 0,1,1,0, 31));
        expect_done(c0 + 34, 0, 1, 1, 0);
        div_sign = 1'b0; div_msb = 1'b1; start_div = 1'b1;
        tick(1);
        start_div = 1'b0;
        tick(36);

        // Divide, negative divisor, remainder sign matches: no correction in DIV_FIX.
        c0 = cyc;
        expect_at(c0 + 1, mk(1,0,0,1,0, 0,1,0,0, 0));
        expect_at(c0 + 33, mk(0,1,0,1,0, 0,1,0,0, 31));
        expect_at(c0 + 34, mk(0,1,0,0,1, 0,1,1,0, 31));
        expect_done(c0 + 34, 0, 1, 1, 0);
        div_sign = 1'b1; div_msb = 1'b1; start_div = 1'b1;
        tick(1);
        start_div = 1'b0;
        tick(36);

        // Divide by zero: immediate completion, flags held, cleared by next start.
        c0 = cyc;
        expect_at(c0 + 1, mk(0,1,0,0,1, 0,1,1,1, 0));
        expect_at(c0 + 2, mk(0,1,0,0,0, 0,1,1,1, 0));
        expect_done(c0 + 1, 0, 1, 1, 1);
        div_sign = 1'b0; div_msb = 1'b1; divisor_zero = 1'b1; start_div = 1'b1;
        tick(1);
        start_div = 1'b0; divisor_zero = 1'b0;
        tick(2);

        // Multiply with a full Booth window sweep (window at cycle j drives cycle j+1).
        c1 = cyc;
        for (int j = 0; j < 8; j++)
            expect_at(c1 + j + 1, mk(sweep_tbl[j][2], sweep_tbl[j][1], sweep_tbl[j][0], 1, 0,
                                     1, 0, 0, 0, j));
        expect_at(c1 + 17, mk(0,1,0,0,1, 1,0,0,0, 15));
        expect_done(c1 + 17, 1, 0, 0, 0);
        start_mult = 1'b1;
        for (int j = 0; j < 8; j++) begin
            booth_window = 3'(j);
            tick(1);
            start_mult = 1'b0;
        end
        booth_window = 3'b000;
        tick(12);

        // Abort: multiply restarted as divide at cycle 5; only the divide completes.
        c0 = cyc;
        expect_at(c0 + 5, mk(1,0,1,1,0, 1,0,0,0, 4));
        expect_at(c0 + 6, mk(0,0,0,1,0, 0,1,0,0, 0));
        expect_at(c0 + 17, mk(0,0,0,1,0, 0,1,0,0, 11));
        expect_at(c0 + 39, mk(0,1,0,0,1, 0,1,1,0, 31));
        expect_done(c0 + 39, 0, 1, 1, 0);
        booth_window = 3'b100; div_sign = 1'b0; div_msb = 1'b1; start_mult = 1'b1;
        tick(1);
        start_mult = 1'b0;
        tick(4);
        start_div = 1'b1;
        tick(1);
        start_div = 1'b0;
        tick(36);

        // Simultaneous starts: multiply wins.
        c0 = cyc;
        expect_at(c0 + 1, mk(0,0,0,1,0, 1,0,0,0, 0));
        expect_at(c0 + 17, mk(0,1,0,0,1, 1,0,0,0, 15));
        expect_done(c0 + 17, 1, 0, 0, 0);
        booth_window = 3'b001; start_mult = 1'b1; start_div = 1'b1;
        tick(1);
        start_mult = 1'b0; start_div = 1'b0;
        tick(20);

        // Reset in the middle of a divide: all outputs clear, no completion.
        c0 = cyc;
        expect_at(c0 + 10, mk(0,0,0,1,0, 0,1,0,0, 9));
        expect_at(c0 + 11, mk(0,0,0,0,0, 0,0,0,0, 0));
        expect_at(c0 + 12, mk(0,1,0,0,0, 0,0,0,0, 0));
        div_sign = 1'b0; div_msb = 1'b1; start_div = 1'b1;
        tick(1);
        start_div = 1'b0;
        tick(9);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(42);

        checks++;
        if (snap_q.size() == 0) passes++;
        else $display("FAIL snap_leftover: got %0d pending expected 0", snap_q.size());
        checks++;
        if (done_q.size() == 0) passes++;
        else $display("FAIL done_leftover: got %0d missing ready pulses expected 0", done_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
